// File: rtl/pulse_bram_streamer_pkg.sv
// Shared constants for the pulse-shape BRAM streamer: FSM encoding, fp32 zero,
// default byte stride and the BRAM read latency the WAIT state is sized for.
package pulse_bram_streamer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [31:0] FP32_ZERO       = 32'h0000_0000;
    localparam int          ADDR_STEP_DEF   = 4;
    localparam int          BRAM_RD_LATENCY = 1;

endpackage

// File: rtl/pulse_bram_streamer.sv
// Reads the accumulated pulse shape out of BRAM one fp32 word per frame slot,
// streams it on valid/ready and optionally zeroes each word behind the read.
module pulse_bram_streamer
    import pulse_bram_streamer_pkg::*;
#(
    parameter int DEPTH         = 1024,
    parameter int ADDR_STEP     = ADDR_STEP_DEF,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_data_in,
    output logic        bram_we,
    output logic        bram_en,
    input  logic [31:0] bram_data_out,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic [31:0] frame_count
);

    localparam int             IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_index;
    logic [31:0]      r_bram_addr;
    logic             r_bram_we;
    logic             r_bram_en;
    logic [31:0]      r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_busy;
    logic [31:0]      r_frame_count;

    logic [1:0]       w_state_nxt;
    logic [IDX_W-1:0] w_index_nxt;
    logic             w_accept;
    logic             w_frame_end;
    logic [31:0]      w_addr_nxt;

    // Next-state and index sequencing; a started frame always runs to its last word
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_accept    = r_m_valid && m_ready;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_ISSUE;
                    w_index_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_OUT;
            ST_OUT: begin
                if (w_accept) begin
                    if (r_index == LAST_IDX) begin
                        w_index_nxt = '0;
                        w_frame_end = 1'b1;
                        w_state_nxt = enable ? ST_ISSUE : ST_IDLE;
                    end else begin
                        w_index_nxt = r_index + IDX_W'(1);
                        w_state_nxt = ST_ISSUE;
                    end
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_index_nxt = '0;
            end
        endcase
        w_addr_nxt = 32'(w_index_nxt) * 32'(ADDR_STEP);
    end

    // Registered BRAM port, stream outputs and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_bram_addr   <= 32'd0;
            r_bram_we     <= 1'b0;
            r_bram_en     <= 1'b0;
            r_m_data      <= 32'd0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_bram_en   <= enable;
                    r_bram_we   <= 1'b0;
                    r_bram_addr <= w_addr_nxt;
                end
                ST_ISSUE: begin
                    r_bram_en <= 1'b0;
                    r_bram_we <= 1'b0;
                end
                // Read data lands now; the optional clear reuses the held address
                ST_WAIT: begin
                    r_m_data  <= bram_data_out;
                    r_m_valid <= 1'b1;
                    r_m_last  <= (r_index == LAST_IDX);
                    r_bram_en <= CLEAR_ON_READ;
                    r_bram_we <= CLEAR_ON_READ;
                end
                ST_OUT: begin
                    r_bram_we <= 1'b0;
                    if (w_accept) begin
                        r_m_valid   <= 1'b0;
                        r_m_last    <= 1'b0;
                        r_bram_en   <= (w_state_nxt == ST_ISSUE);
                        r_bram_addr <= w_addr_nxt;
                    end else begin
                        r_bram_en <= 1'b0;
                    end
                end
                default: begin
                    r_bram_en <= 1'b0;
                    r_bram_we <= 1'b0;
                end
            endcase
        end
    end

    assign bram_addr    = r_bram_addr;
    assign bram_data_in = FP32_ZERO;
    assign bram_we      = r_bram_we;
    assign bram_en      = r_bram_en;
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign m_last       = r_m_last;
    assign busy         = r_busy;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_pulse_bram_streamer.sv
// Directed bench: two streamers (clear-on-read on/off) share stimulus, each
// with its own behavioural BRAM that reloads the pulse table while in reset.
module tb_pulse_bram_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, m_ready;

    logic [31:0] a0, din0, rd0, md0, fc0;
    logic        we0, en0, mv0, ml0, busy0;
    logic [31:0] a1, din1, rd1, md1, fc1;
    logic        we1, en1, mv1, ml1, busy1;

    logic [31:0] pre [4] = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD};
    logic [31:0] mem0 [4];
    logic [31:0] mem1 [4];

    int n_assert = 0;
    int n_fail   = 0;
    int rd_cnt0, wr4_cnt0, last_hs0;
    logic we1_seen = 1'b0;
    int rd_snap;

    pulse_bram_streamer #(.DEPTH(4), .ADDR_STEP(4), .CLEAR_ON_READ(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bram_addr(a0), .bram_data_in(din0), .bram_we(we0), .bram_en(en0),
        .bram_data_out(rd0), .m_data(md0), .m_valid(mv0), .m_ready(m_ready),
        .m_last(ml0), .busy(busy0), .frame_count(fc0)
    );

    pulse_bram_streamer #(.DEPTH(4), .ADDR_STEP(4), .CLEAR_ON_READ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bram_addr(a1), .bram_data_in(din1), .bram_we(we1), .bram_en(en1),
        .bram_data_out(rd1), .m_data(md1), .m_valid(mv1), .m_ready(m_ready),
        .m_last(ml1), .busy(busy1), .frame_count(fc1)
    );

    // Read-first BRAM models with one cycle of read latency
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem0[i] <= pre[i];
                mem1[i] <= pre[i];
            end
            rd0 <= 32'd0;
            rd1 <= 32'd0;
        end else begin
            if (en0) begin
                if (we0) mem0[a0[3:2]] <= din0;
                rd0 <= mem0[a0[3:2]];
            end
            if (en1) begin
                if (we1) mem1[a1[3:2]] <= din1;
                rd1 <= mem1[a1[3:2]];
            end
        end
    end

    // Port activity monitors
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt0  <= 0;
            wr4_cnt0 <= 0;
            last_hs0 <= 0;
        end else begin
            if (en0 && !we0) rd_cnt0 <= rd_cnt0 + 1;
            if (en0 && we0 && a0 == 32'd4) wr4_cnt0 <= wr4_cnt0 + 1;
            if (mv0 && m_ready && ml0) last_hs0 <= last_hs0 + 1;
        end
    end

    always @(posedge clk) begin
        if (en1 && we1) we1_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the first OUT cycle of word idx and checks it on both DUTs
    task automatic expect_word(input int idx, input logic [31:0] e0, input logic [31:0] e1,
                               input logic elast);
        @(negedge clk);
        for (int k = 0; k < 8 && !mv0; k++) @(negedge clk);
        chk($sformatf("w%0d_valid", idx), {31'd0, mv0}, 32'd1);
        chk($sformatf("w%0d_data0", idx), md0, e0);
        chk($sformatf("w%0d_data1", idx), md1, e1);
        chk($sformatf("w%0d_last0", idx), {31'd0, ml0}, {31'd0, elast});
        chk($sformatf("w%0d_last1", idx), {31'd0, ml1}, {31'd0, elast});
        chk($sformatf("w%0d_addr", idx), a0, 32'(idx * 4));
        chk($sformatf("w%0d_clr", idx), {30'd0, en0, we0}, 32'd3);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, mv0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_en_we", {30'd0, en0, we0}, 32'd0);
        chk("rst_addr", a0, 32'd0);
        chk("rst_data", md0, 32'd0);
        chk("rst_last", {31'd0, ml0}, 32'd0);
        chk("rst_fc", fc0, 32'd0);
        chk("rst_din", din0, 32'd0);

        // Single frame, enable pulsed, latency checked cycle by cycle
        rst_n = 1'b1;
        @(negedge clk);
        chk("lat_issue_en", {31'd0, en0}, 32'd1);
        chk("lat_issue_addr", a0, 32'd0);
        chk("lat_issue_valid", {31'd0, mv0}, 32'd0);
        chk("lat_issue_busy", {31'd0, busy0}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("lat_wait_en", {31'd0, en0}, 32'd0);
        chk("lat_wait_valid", {31'd0, mv0}, 32'd0);
        @(negedge clk);
        chk("lat_out_valid", {31'd0, mv0}, 32'd1);
        chk("lat_out_data", md0, pre[0]);
        chk("lat_out_clr", {30'd0, en0, we0}, 32'd3);
        chk("lat_out_addr", a0, 32'd0);
        expect_word(1, pre[1], pre[1], 1'b0);
        expect_word(2, pre[2], pre[2], 1'b0);
        expect_word(3, pre[3], pre[3], 1'b1);
        @(negedge clk);
        chk("f1_fc0", fc0, 32'd1);
        chk("f1_fc1", fc1, 32'd1);
        chk("f1_busy", {31'd0, busy0}, 32'd0);
        chk("f1_valid", {31'd0, mv0}, 32'd0);
        chk("f1_last", {31'd0, ml0}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("clr_mem0_%0d", i), mem0[i], 32'd0);
            chk($sformatf("keep_mem1_%0d", i), mem1[i], pre[i]);
        end
        chk("f1_reads", 32'(rd_cnt0), 32'd4);
        chk("noclr_we", {31'd0, we1_seen}, 32'd0);

        // Backpressure on word 1
        rst_n = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        expect_word(0, pre[0], pre[0], 1'b0);
        @(negedge clk);
        m_ready = 1'b0;
        expect_word(1, pre[1], pre[1], 1'b0);
        rd_snap = rd_cnt0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_data", md0, pre[1]);
            chk("bp_hold_valid", {31'd0, mv0}, 32'd1);
            chk("bp_hold_en", {31'd0, en0}, 32'd0);
        end
        chk("bp_no_read", 32'(rd_cnt0), 32'(rd_snap));
        chk("bp_one_clear", 32'(wr4_cnt0), 32'd1);
        m_ready = 1'b1;
        expect_word(2, pre[2], pre[2], 1'b0);
        expect_word(3, pre[3], pre[3], 1'b1);
        @(negedge clk);
        chk("bp_clear_total", 32'(wr4_cnt0), 32'd1);
        chk("bp_fc", fc0, 32'd1);

        // Continuous streaming: back-to-back frames with enable held
        rst_n = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) expect_word(i, pre[i], pre[i], (i == 3));
        @(negedge clk);
        chk("cont_wrap_en", {30'd0, en0, we0}, 32'd2);
        chk("cont_wrap_addr", a0, 32'd0);
        chk("cont_fc1", fc0, 32'd1);
        chk("cont_busy", {31'd0, busy0}, 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) expect_word(i, 32'd0, pre[i], (i == 3));
        @(negedge clk);
        chk("cont_fc2", fc0, 32'd2);
        chk("cont_last_cnt", 32'(last_hs0), 32'd2);
        chk("cont_idle", {31'd0, busy0}, 32'd0);

        // Asynchronous reset while holding word 2
        enable = 1'b1;
        expect_word(0, 32'd0, pre[0], 1'b0);
        expect_word(1, 32'd0, pre[1], 1'b0);
        @(negedge clk);
        m_ready = 1'b0;
        expect_word(2, 32'd0, pre[2], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, mv0}, 32'd0);
        chk("mid_rst_fc", fc0, 32'd0);
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_en_we", {30'd0, en0, we0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("restart_en", {30'd0, en0, we0}, 32'd2);
        chk("restart_addr", a0, 32'd0);
        chk("noclr_we_end", {31'd0, we1_seen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
